// File: rtl/spisd_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package spisd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_NCR,
        ST_RESP,
        ST_RDWAIT,
        ST_TOKEN,
        ST_DATA,
        ST_DCRC
    } spisd_state_t;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_SD_SEND_OP   = 6'd41;
    localparam logic [5:0] CMD_APP          = 6'd55;
    localparam logic [5:0] CMD_READ_OCR     = 6'd58;

    localparam logic [7:0] R1_READY        = 8'h00;
    localparam logic [7:0] R1_IDLE         = 8'h01;
    localparam logic [7:0] R1_ILLEGAL      = 8'h04;
    localparam logic [7:0] R1_ILLEGAL_IDLE = 8'h05;

    localparam logic [31:0] OCR_VALUE  = 32'hC0FF8000;
    localparam logic [7:0]  DATA_TOKEN = 8'hFE;
    localparam logic [7:0]  FILL_BYTE  = 8'hFF;
    localparam int          BLOCK_LEN  = 512;

endpackage

// File: rtl/spisd_sck_sync.sv
// Brings SCK, CS_n and MOSI into the clk50 domain and derives SCK edge strobes.
module spisd_sck_sync (
    input  logic i_clk50,
    input  logic i_reset_n,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_n,
    output logic o_mosi
);
    logic [2:0] r_sck;
    logic [1:0] r_cs_n;
    logic [1:0] r_mosi;

    always_ff @(posedge i_clk50 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sck  <= 3'b000;
            r_cs_n <= 2'b11;
            r_mosi <= 2'b11;
        end else begin
            r_sck  <= {r_sck[1:0], i_sck};
            r_cs_n <= {r_cs_n[0], i_cs_n};
            r_mosi <= {r_mosi[0], i_mosi};
        end
    end

    // r_sck[2] is an extra history bit used only for edge detection
    assign o_sck_rise = r_sck[1] & ~r_sck[2];
    assign o_sck_fall = ~r_sck[1] & r_sck[2];
    assign o_cs_n     = r_cs_n[1];
    assign o_mosi     = r_mosi[1];

endmodule

// File: rtl/spisd_responder.sv
// SPI-mode SD card responder: decodes command frames, answers R1/R3/R7 and
// serves single-block reads of a counting data pattern.
//
// state  | meaning
// HUNT   | waiting for a start bit on MOSI
// CMD    | shifting in the rest of the 48-bit command frame
// NCR    | sending Ncr fill bits before the reply
// RESP   | sending R1 / R3 / R7 bytes
// RDWAIT | fill bytes between the read R1 and the data token
// TOKEN  | sending the start-block token
// DATA   | sending the 512-byte block
// DCRC   | sending the two dummy CRC bytes
module spisd_responder #(
    parameter int ACMD41_BUSY_COUNT = 2,
    parameter int NCR_BYTES         = 1,
    parameter int READ_WAIT_BYTES   = 2
) (
    input  logic clk50,
    input  logic reset_n,
    input  logic spisdcard_clk,
    input  logic spisdcard_cs_n,
    input  logic spisdcard_mosi,
    output logic spisdcard_miso,
    output logic idle_o
);
    import spisd_pkg::*;

    localparam int BUSY_W = ($clog2(ACMD41_BUSY_COUNT + 1) < 2) ? 2 : $clog2(ACMD41_BUSY_COUNT + 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(ACMD41_BUSY_COUNT);
    localparam logic [15:0] NCR_BITS  = 16'(NCR_BYTES * 8);
    localparam logic [15:0] WAIT_BITS = 16'(READ_WAIT_BYTES * 8);
    localparam logic [8:0]  LAST_DATA = 9'(BLOCK_LEN - 1);

    logic        w_rise;
    logic        w_fall;
    logic        w_cs_n;
    logic        w_mosi;
    logic [5:0]  w_idx;
    logic [11:0] w_arg_lo;
    logic [7:0]  w_r1;
    logic [7:0]  w_next_byte;

    spisd_state_t      r_state;
    logic [44:0]       r_rx;
    logic [5:0]        r_rxcnt;
    logic [39:0]       r_resp;
    logic [8:0]        r_byte;
    logic [7:0]        r_tx;
    logic [2:0]        r_bitcnt;
    logic [15:0]       r_cnt;
    logic [7:0]        r_dval;
    logic              r_read;
    logic              r_miso;
    logic              r_idle;
    logic              r_app;
    logic [BUSY_W-1:0] r_busy;

    spisd_sck_sync u_sync (
        .i_clk50    (clk50),
        .i_reset_n  (reset_n),
        .i_sck      (spisdcard_clk),
        .i_cs_n     (spisdcard_cs_n),
        .i_mosi     (spisdcard_mosi),
        .o_sck_rise (w_rise),
        .o_sck_fall (w_fall),
        .o_cs_n     (w_cs_n),
        .o_mosi     (w_mosi)
    );

    // r_rx holds frame bits 45..1 when the end bit arrives
    assign w_idx    = r_rx[44:39];
    assign w_arg_lo = r_rx[18:7];
    assign w_r1     = {7'b0, r_idle};

    always_comb begin
        w_next_byte = FILL_BYTE;
        case (r_state)
            ST_NCR:    w_next_byte = r_resp[39:32];
            ST_RESP:   w_next_byte = (r_byte == 9'd0) ? DATA_TOKEN : r_resp[39:32];
            ST_RDWAIT: w_next_byte = DATA_TOKEN;
            ST_TOKEN:  w_next_byte = r_dval;
            ST_DATA:   w_next_byte = (r_byte == LAST_DATA) ? FILL_BYTE : r_dval;
            default:   w_next_byte = FILL_BYTE;
        endcase
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_HUNT;
            r_rx     <= '0;
            r_rxcnt  <= '0;
            r_resp   <= '0;
            r_byte   <= '0;
            r_tx     <= '1;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_dval   <= '0;
            r_read   <= 1'b0;
            r_miso   <= 1'b1;
            r_idle   <= 1'b1;
            r_app    <= 1'b0;
            r_busy   <= '0;
        end else if (w_cs_n) begin
            r_state  <= ST_HUNT;
            r_miso   <= 1'b1;
            r_rxcnt  <= '0;
            r_bitcnt <= '0;
            r_byte   <= '0;
            r_cnt    <= '0;
            r_read   <= 1'b0;
        end else begin
            case (r_state)
                ST_HUNT: if (w_rise && !w_mosi) begin
                    r_rx    <= '0;
                    r_rxcnt <= 6'd1;
                    r_state <= ST_CMD;
                end
                ST_CMD: if (w_rise) begin
                    r_rx    <= {r_rx[43:0], w_mosi};
                    r_rxcnt <= r_rxcnt + 6'd1;
                    if (r_rxcnt == 6'd1 && !w_mosi) begin
                        r_state <= ST_HUNT;
                    end else if (r_rxcnt == 6'd47) begin
                        r_state <= ST_NCR;
                        r_cnt   <= '0;
                        r_byte  <= '0;
                        r_read  <= 1'b0;
                        r_app   <= 1'b0;
                        case (w_idx)
                            CMD_GO_IDLE: begin
                                r_resp <= {R1_IDLE, 32'h0};
                                r_idle <= 1'b1;
                            end
                            CMD_SEND_IF_COND: begin
                                r_resp <= {(r_idle ? R1_IDLE : R1_READY), 16'h0, 4'h0, w_arg_lo};
                                r_byte <= 9'd4;
                            end
                            CMD_APP: begin
                                r_resp <= {w_r1, 32'h0};
                                r_app  <= 1'b1;
                            end
                            CMD_SD_SEND_OP: begin
                                if (!r_app) begin
                                    r_resp <= {R1_ILLEGAL | w_r1, 32'h0};
                                end else if (r_busy < BUSY_MAX) begin
                                    r_resp <= {R1_IDLE, 32'h0};
                                    r_busy <= r_busy + BUSY_W'(1);
                                end else begin
                                    r_resp <= {R1_READY, 32'h0};
                                    r_idle <= 1'b0;
                                end
                            end
                            CMD_READ_OCR: begin
                                r_resp <= {w_r1, OCR_VALUE};
                                r_byte <= 9'd4;
                            end
                            CMD_READ_SINGLE: begin
                                if (r_idle) begin
                                    r_resp <= {R1_ILLEGAL_IDLE, 32'h0};
                                end else begin
                                    r_resp <= {R1_READY, 32'h0};
                                    r_read <= 1'b1;
                                    r_dval <= w_arg_lo[7:0];
                                end
                            end
                            default: r_resp <= {R1_ILLEGAL | w_r1, 32'h0};
                        endcase
                    end
                end
                ST_NCR: if (w_fall) begin
                    if (r_cnt == NCR_BITS) begin
                        r_miso   <= w_next_byte[7];
                        r_tx     <= {w_next_byte[6:0], 1'b1};
                        r_bitcnt <= '0;
                        r_resp   <= r_resp << 8;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RDWAIT: if (w_fall) begin
                    if (r_cnt == WAIT_BITS) begin
                        r_miso   <= w_next_byte[7];
                        r_tx     <= {w_next_byte[6:0], 1'b1};
                        r_bitcnt <= '0;
                        r_state  <= ST_TOKEN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: if (w_fall) begin
                    if (r_bitcnt != 3'd7) begin
                        r_miso   <= r_tx[7];
                        r_tx     <= {r_tx[6:0], 1'b1};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end else begin
                        case (r_state)
                            ST_RESP: begin
                                if (r_byte != 9'd0) begin
                                    r_miso   <= w_next_byte[7];
                                    r_tx     <= {w_next_byte[6:0], 1'b1};
                                    r_bitcnt <= '0;
                                    r_resp   <= r_resp << 8;
                                    r_byte   <= r_byte - 9'd1;
                                end else if (!r_read) begin
                                    r_miso  <= 1'b1;
                                    r_state <= ST_HUNT;
                                end else if (WAIT_BITS == 16'd0) begin
                                    r_miso   <= w_next_byte[7];
                                    r_tx     <= {w_next_byte[6:0], 1'b1};
                                    r_bitcnt <= '0;
                                    r_state  <= ST_TOKEN;
                                end else begin
                                    // this fall already emits the first wait bit
                                    r_miso  <= 1'b1;
                                    r_cnt   <= 16'd1;
                                    r_state <= ST_RDWAIT;
                                end
                            end
                            ST_TOKEN: begin
                                r_miso   <= w_next_byte[7];
                                r_tx     <= {w_next_byte[6:0], 1'b1};
                                r_bitcnt <= '0;
                                r_dval   <= r_dval + 8'd1;
                                r_byte   <= '0;
                                r_state  <= ST_DATA;
                            end
                            ST_DATA: begin
                                r_miso   <= w_next_byte[7];
                                r_tx     <= {w_next_byte[6:0], 1'b1};
                                r_bitcnt <= '0;
                                if (r_byte == LAST_DATA) begin
                                    r_byte  <= '0;
                                    r_state <= ST_DCRC;
                                end else begin
                                    r_byte <= r_byte + 9'd1;
                                    r_dval <= r_dval + 8'd1;
                                end
                            end
                            ST_DCRC: begin
                                if (r_byte == 9'd1) begin
                                    r_miso  <= 1'b1;
                                    r_read  <= 1'b0;
                                    r_byte  <= '0;
                                    r_state <= ST_HUNT;
                                end else begin
                                    r_miso   <= w_next_byte[7];
                                    r_tx     <= {w_next_byte[6:0], 1'b1};
                                    r_bitcnt <= '0;
                                    r_byte   <= 9'd1;
                                end
                            end
                            default: r_state <= ST_HUNT;
                        endcase
                    end
                end
            endcase
        end
    end

    // released chip select forces MISO high without waiting for the synchroniser
    assign spisdcard_miso = r_miso | spisdcard_cs_n;
    assign idle_o         = r_idle;

endmodule
